// File: rtl/cache_arb_pkg.sv
// Shared types and parameter helpers for the cache/data memory arbiter.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IC_BURST = 2'd1,
        DP_XFER  = 2'd2
    } arb_state_t;

    // Default geometry used by the arbiter instance parameters
    localparam int ARB_ADDR_W     = 32;
    localparam int ARB_DATA_W     = 32;
    localparam int ARB_LINE_WORDS = 4;

    // Beat counter width: one count per word of an icache line
    function automatic int beat_cnt_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Address bits covered by one icache line
    function automatic int line_off_bits(input int line_words, input int data_w);
        return $clog2(line_words * (data_w / 8));
    endfunction

    // Byte distance between consecutive memory words
    function automatic int byte_stride(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/cache_arb_rr2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the side not served last.
module cache_arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // req[0] is the icache side; last=1 means the icache was served most recently
    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !last)) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/cache_mem_arb.sv
// Arbitrates the single memory port between icache line refills and the core data port.
module cache_mem_arb
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int LINE_WORDS = ARB_LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_rvalid,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_done,
    input  logic              dp_req,
    input  logic              dp_we,
    input  logic [ADDR_W-1:0] dp_addr,
    input  logic [DATA_W-1:0] dp_wdata,
    output logic              dp_ack,
    output logic [DATA_W-1:0] dp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = beat_cnt_w(LINE_WORDS);
    localparam int OFF_W = line_off_bits(LINE_WORDS, DATA_W);
    localparam logic [ADDR_W-1:0] STRIDE    = ADDR_W'(byte_stride(DATA_W));
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             last_ic;
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       gnt;
    logic             last_beat;

    cache_arb_rr2 u_rr2 (
        .req  ({dp_req, ic_req}),
        .last (last_ic),
        .gnt  (gnt)
    );

    assign last_beat = (beat_cnt == LAST_BEAT);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant from IDLE, leave a transaction only on its final ack
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt[0]) begin
                    state_nxt = IC_BURST;
                end else if (gnt[1]) begin
                    state_nxt = DP_XFER;
                end
            end
            IC_BURST: if (mem_ack && last_beat) state_nxt = IDLE;
            DP_XFER:  if (mem_ack) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Requester-side responses are passed straight through from the memory ack
    always_comb begin
        ic_rvalid = 1'b0;
        ic_rdata  = '0;
        ic_done   = 1'b0;
        dp_ack    = 1'b0;
        dp_rdata  = '0;
        case (state)
            IC_BURST: begin
                if (mem_ack) begin
                    ic_rvalid = 1'b1;
                    ic_rdata  = mem_rdata;
                    ic_done   = last_beat;
                end
            end
            DP_XFER: begin
                if (mem_ack) begin
                    dp_ack   = 1'b1;
                    dp_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    // Registered memory-side request, address walk, beat counter and fairness flag
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ic   <= 1'b0;
            beat_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt[0]) begin
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ic_addr & ~LINE_MASK;
                        beat_cnt <= '0;
                        last_ic  <= 1'b1;
                    end else if (gnt[1]) begin
                        mem_req   <= 1'b1;
                        mem_we    <= dp_we;
                        mem_addr  <= dp_addr;
                        mem_wdata <= dp_wdata;
                        last_ic   <= 1'b0;
                    end
                end
                IC_BURST: begin
                    if (mem_ack) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        mem_addr <= mem_addr + STRIDE;
                        if (last_beat) begin
                            mem_req <= 1'b0;
                        end
                    end
                end
                DP_XFER: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
